// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the bus_fabric shared-bus arbiter.
package bus_fabric_pkg;

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    localparam int BURST_W = 8;

endpackage

// File: rtl/bus_fabric_rr_arbiter.sv
// rr_arbiter: first requester at or after ptr (wrapping), ignoring masked-out masters.
module rr_arbiter
    import bus_fabric_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] cand;

    assign cand = req & ~excl;

    // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1].
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && cand[i] && (i >= int'(ptr))) begin
                any     = 1'b1;
                pick[i] = 1'b1;
                idx     = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && cand[i] && (i < int'(ptr))) begin
                any     = 1'b1;
                pick[i] = 1'b1;
                idx     = IW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: round-robin shared bus with burst-length preemption and a bus keeper.
// Define BUS_FABRIC_LOCK_EN to add a per-master lock input that blocks preemption.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int MASTERS   = 4,
    parameter  int MAX_BURST = 8,
    localparam int OW        = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [MASTERS-1:0]         req,
    input  logic [MASTERS*WIDTH-1:0]   data_in,
`ifdef BUS_FABRIC_LOCK_EN
    input  logic [MASTERS-1:0]         lock,
`endif
    output logic [MASTERS-1:0]         gnt,
    output logic [WIDTH-1:0]           bus,
    output logic                       bus_valid,
    output logic [OW-1:0]              owner
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    state_t               state, state_nx;
    logic [MASTERS-1:0]   gnt_nx;
    logic [OW-1:0]        owner_nx, rr_ptr, rr_ptr_nx;
    logic [BURST_W-1:0]   burst_cnt, burst_nx;
    logic [WIDTH-1:0]     keeper, owner_data;
    logic                 lock_hold;
    logic [MASTERS-1:0]   arb_pick;
    logic [OW-1:0]        arb_idx;
    logic                 arb_any;

    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
        return (v >= MAX_B) ? v : v + 1'b1;
    endfunction

    function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] i);
        return (int'(i) == MASTERS - 1) ? '0 : i + 1'b1;
    endfunction

    // The owner is always excluded; when it has dropped req that costs nothing.
    rr_arbiter #(.N(MASTERS), .IW(OW)) u_arb (
        .req  (req),
        .ptr  (rr_ptr),
        .excl (gnt),
        .pick (arb_pick),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (gnt[i]) owner_data = data_in[i*WIDTH +: WIDTH];
        end
    end

    assign bus_valid = |(req & gnt);
    assign bus       = bus_valid ? owner_data : keeper;

`ifdef BUS_FABRIC_LOCK_EN
    assign lock_hold = |(lock & gnt);
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        burst_nx  = burst_cnt;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nx  = OWNED;
                    gnt_nx    = arb_pick;
                    owner_nx  = arb_idx;
                    rr_ptr_nx = next_ptr(arb_idx);
                    burst_nx  = '0;
                end
            end
            OWNED: begin
                if (!bus_valid && !arb_any) begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    owner_nx = '0;
                    burst_nx = '0;
                end else if (!bus_valid || (burst_cnt == MAX_B && arb_any && !lock_hold)) begin
                    gnt_nx    = arb_pick;
                    owner_nx  = arb_idx;
                    rr_ptr_nx = next_ptr(arb_idx);
                    burst_nx  = '0;
                end else begin
                    burst_nx = sat_inc(burst_cnt);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            keeper    <= '0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            owner     <= owner_nx;
            rr_ptr    <= rr_ptr_nx;
            burst_cnt <= burst_nx;
            if (bus_valid) keeper <= owner_data;
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric (WIDTH=16, MASTERS=4, MAX_BURST=4).
module tb_bus_fabric;

    localparam int W  = 16;
    localparam int M  = 4;
    localparam int MB = 4;
`ifdef BUS_FABRIC_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req, lock, gnt;
    logic [63:0] data_in;
    logic [15:0] bus;
    logic        bus_valid;
    logic [1:0]  owner;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: owner index (-1 = idle), pointer, burst count, keeper.
    int          m_own, m_ptr, m_cnt;
    logic [15:0] m_keep;

    typedef struct {
        logic [3:0]  req;
        logic [63:0] data;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        valid;
        logic [15:0] bus;
    } vec_t;

    vec_t tbl[13];

    always #5 CLK = ~CLK;

    bus_fabric #(.WIDTH(W), .MASTERS(M), .MAX_BURST(MB)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req       (req),
        .data_in   (data_in),
`ifdef BUS_FABRIC_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .bus       (bus),
        .bus_valid (bus_valid),
        .owner     (owner)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start, input int excl);
        for (int k = 0; k < M; k++) begin
            int i;
            i = (start + k) % M;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_ptr  = 0;
        m_cnt  = 0;
        m_keep = 16'h0;
    endtask

    task automatic model_grant(input int p);
        m_own = p;
        m_ptr = (p + 1) % M;
        m_cnt = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [63:0] d, input logic [3:0] l);
        int p;
        if (m_own >= 0 && r[m_own]) m_keep = d[m_own*16 +: 16];
        if (m_own < 0) begin
            p = pick(r, m_ptr, -1);
            if (p >= 0) model_grant(p);
        end else if (!r[m_own]) begin
            p = pick(r, m_ptr, -1);
            if (p >= 0) model_grant(p);
            else begin
                m_own = -1;
                m_cnt = 0;
            end
        end else begin
            p = pick(r, m_ptr, m_own);
            if (m_cnt == MB && p >= 0 && !(LOCK_EN && l[m_own])) model_grant(p);
            else if (m_cnt < MB) m_cnt++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0]  e_gnt;
        logic        e_valid;
        logic [15:0] e_bus;
        e_gnt   = (m_own < 0) ? 4'b0 : (4'b0001 << m_own);
        e_valid = (m_own >= 0) && req[m_own];
        e_bus   = e_valid ? data_in[m_own*16 +: 16] : m_keep;
        cmp({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        cmp({tag, ".owner"}, 32'(owner), (m_own < 0) ? 32'd0 : 32'(m_own));
        cmp({tag, ".bus_valid"}, 32'(bus_valid), 32'(e_valid));
        cmp({tag, ".bus"}, 32'(bus), 32'(e_bus));
        cmp({tag, ".rr_ptr"}, 32'(dut.rr_ptr), 32'(m_ptr));
        cmp({tag, ".burst"}, 32'(dut.burst_cnt), 32'(m_cnt));
        cmp({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic apply(input logic [3:0] r, input logic [63:0] d, input logic [3:0] l, input string tag);
        req     = r;
        data_in = d;
        lock    = l;
        #1;
        check_model(tag);
    endtask

    task automatic finish_cycle();
        model_step(req, data_in, lock);
        @(negedge CLK);
    endtask

    task automatic cycle(input logic [3:0] r, input logic [63:0] d, input logic [3:0] l, input string tag);
        apply(r, d, l, tag);
        finish_cycle();
    endtask

    task automatic do_reset();
        RST  = 1'b1;
        req  = 4'b0;
        lock = 4'b0;
        #1;
        cmp("rst.gnt", 32'(gnt), 32'd0);
        cmp("rst.owner", 32'(owner), 32'd0);
        cmp("rst.bus_valid", 32'(bus_valid), 32'd0);
        cmp("rst.bus", 32'(bus), 32'd0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  r;
        logic [3:0]  l;
        RST     = 1'b1;
        req     = 4'b0;
        lock    = 4'b0;
        data_in = 64'h0;
        model_reset();

        tbl[0]  = '{4'b0110, 64'h0000_5A5A_A5A5_0000, 4'b0000, 2'd0, 1'b0, 16'h0000};
        tbl[1]  = '{4'b0110, 64'h0000_5A5A_A5A5_0000, 4'b0010, 2'd1, 1'b1, 16'hA5A5};
        tbl[2]  = '{4'b0100, 64'h0000_5A5A_FFFF_0000, 4'b0010, 2'd1, 1'b0, 16'hA5A5};
        tbl[3]  = '{4'b0100, 64'h0000_5A5A_FFFF_0000, 4'b0100, 2'd2, 1'b1, 16'h5A5A};
        tbl[4]  = '{4'b0000, 64'h0000_5A5A_FFFF_0000, 4'b0100, 2'd2, 1'b0, 16'h5A5A};
        tbl[5]  = '{4'b0000, 64'h0000_5A5A_FFFF_0000, 4'b0000, 2'd0, 1'b0, 16'h5A5A};
        tbl[6]  = '{4'b1000, 64'h3333_0000_0000_1111, 4'b0000, 2'd0, 1'b0, 16'h5A5A};
        for (int i = 7; i <= 11; i++)
            tbl[i] = '{4'b1001, 64'h3333_0000_0000_1111, 4'b1000, 2'd3, 1'b1, 16'h3333};
        tbl[12] = '{4'b1001, 64'h3333_0000_0000_1111, 4'b0001, 2'd0, 1'b1, 16'h1111};

        @(negedge CLK);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].req, tbl[i].data, 4'b0, $sformatf("tbl%0d", i));
            cmp($sformatf("tbl%0d.gnt_k", i), 32'(gnt), 32'(tbl[i].gnt));
            cmp($sformatf("tbl%0d.owner_k", i), 32'(owner), 32'(tbl[i].owner));
            cmp($sformatf("tbl%0d.valid_k", i), 32'(bus_valid), 32'(tbl[i].valid));
            cmp($sformatf("tbl%0d.bus_k", i), 32'(bus), 32'(tbl[i].bus));
            finish_cycle();
        end

        // Master 2 alone for ten cycles: grant stays, counter saturates.
        cycle(4'b0100, 64'h0000_2222_0000_0000, 4'b0, "sole_hand");
        for (int k = 0; k < 10; k++) begin
            apply(4'b0100, 64'h0000_2222_0000_0000, 4'b0, "sole");
            cmp("sole.gnt_k", 32'(gnt), 32'h4);
            finish_cycle();
        end
        cmp("sole.burst_sat", 32'(dut.burst_cnt), 32'd4);

`ifdef BUS_FABRIC_LOCK_EN
        for (int k = 0; k < 20; k++) begin
            apply(4'b1100, 64'h4444_2222_0000_0000, 4'b0100, "lock");
            cmp("lock.gnt_k", 32'(gnt), 32'h4);
            finish_cycle();
        end
        cycle(4'b1000, 64'h4444_2222_0000_0000, 4'b0100, "lock_drop");
        apply(4'b1000, 64'h4444_2222_0000_0000, 4'b0000, "lock_after");
        cmp("lock_after.gnt_k", 32'(gnt), 32'h8);
        finish_cycle();
`endif

        // Reset mid-burst, then the first grant restarts from pointer 0.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(4'b1000, 64'h1234_0000_0000_0000, 4'b0, "pre_rst");
        apply(4'b1000, 64'h1234_0000_0000_0000, 4'b0, "mid_burst");
        cmp("mid_burst.bus_k", 32'(bus), 32'h1234);
        #2 RST = 1'b1;
        #1;
        cmp("arst.gnt", 32'(gnt), 32'd0);
        cmp("arst.bus", 32'(bus), 32'd0);
        cmp("arst.bus_valid", 32'(bus_valid), 32'd0);
        cmp("arst.owner", 32'(owner), 32'd0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        cycle(4'b1010, 64'h0000_0000_7777_0000, 4'b0, "post_rst");
        apply(4'b1010, 64'h0000_0000_7777_0000, 4'b0, "post_rst2");
        cmp("post_rst.gnt_k", 32'(gnt), 32'h2);
        finish_cycle();

        // Randomized traffic against the model, with occasional resets.
        r = 4'b0;
        l = 4'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) l = 4'($urandom_range(0, 15));
            cycle(r, {$urandom, $urandom}, l, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 Parameter WIDTH, default 16, bus data width in bits; legal range 8..32.
REQ-002 Parameter MASTERS, default 4, number of bus masters; legal range 1..8.
REQ-003 Parameter MAX_BURST, default 8, maximum consecutive owned cycles before preemption when another master waits; legal range 1..255.
REQ-004 Port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port RST  input  1  reset, asynchronous and active-high.
REQ-006 Port req  input  MASTERS  per-master bus request, level-sensitive.
REQ-007 Port data_in  input  MASTERS*WIDTH  per-master drive data; master i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port lock  input  MASTERS  per-master burst lock; present only with BUS_FABRIC_LOCK_EN.
REQ-009 Port gnt  output  MASTERS  registered one-hot grant; all-zero when no owner.
REQ-010 Port bus  output  WIDTH  shared bus value; replaces the tri-state bus.
REQ-011 Port bus_valid  output  1  high when the owner drives bus this cycle.
REQ-012 Port owner  output  max(1,$clog2(MASTERS))  index of current owner; 0 when idle.

Function
REQ-013 The FSM SHALL have two states: IDLE (no owner) and OWNED (exactly one gnt bit high).
REQ-014 In IDLE with any req high, the block SHALL grant, at the next edge, the first requester at or after rr_ptr, searching upward with wrap from MASTERS-1 to 0; request-to-grant latency is 1 cycle.
REQ-015 rr_ptr SHALL be set to (granted index + 1) mod MASTERS on every new grant.
REQ-016 In OWNED, bus SHALL equal the owner's data_in slice combinationally and bus_valid SHALL equal req[owner].
REQ-017 When bus_valid is low, bus SHALL hold the last value driven with bus_valid high (keeper register).
REQ-018 Owner deasserting req SHALL release the bus at the next edge; if other requests are pending, the new grant SHALL take effect at that same edge (no dead cycle).
REQ-019 An 8-bit burst counter SHALL clear on each new grant and increment each OWNED cycle, saturating at MAX_BURST.
REQ-020 At burst count == MAX_BURST with another req high, the grant SHALL move at the next edge to the next requester by round-robin, excluding the current owner.
REQ-021 At burst count == MAX_BURST with no other requester, the owner SHALL keep the bus indefinitely.
REQ-022 Simultaneous requests SHALL be resolved solely by rr_ptr order; there is no fixed priority.
REQ-023 With MASTERS == 1, master 0 SHALL be granted whenever req[0] is high; preemption never occurs.
REQ-024 gnt SHALL never have more than one bit high in any cycle.

Reset
REQ-025 RST high SHALL immediately force state IDLE, gnt=0, owner=0, bus_valid=0, bus=0, keeper=0, rr_ptr=0, burst counter=0, including mid-burst.
REQ-026 After RST falls, the first grant SHALL follow REQ-014 with rr_ptr=0.

Configuration
REQ-027 With BUS_FABRIC_LOCK_EN defined, an owner with lock[owner] high SHALL NOT be preempted by REQ-020; it releases only by dropping req.
REQ-028 Without BUS_FABRIC_LOCK_EN, the lock port SHALL be absent and preemption SHALL always apply.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, OWNED) and the burst-counter width constant (8).
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr, exclude mask; outputs one-hot pick and index).

Verification
REQ-031 Reset, then req=4'b0110 at same edge -> gnt=4'b0010 one cycle later, owner=1, rr_ptr=2.
REQ-032 Master 1 owns, drives 16'hA5A5, then drops req while req[2] is high -> gnt=4'b0100 at next edge, bus holds 16'hA5A5 during the handover cycle with bus_valid=0.
REQ-033 MAX_BURST=4, master 3 holds req with req[0] high -> gnt moves 4'b1000 to 4'b0001 after 4 owned cycles (wrap-around).
REQ-034 MAX_BURST=4, master 2 sole requester for 10 cycles -> gnt stays 4'b0100, counter saturates at 4.
REQ-035 BUS_FABRIC_LOCK_EN defined, lock[2]=1 with master 2 owning and req[3]=1 -> no preemption after 20 cycles; clearing req[2] yields gnt=4'b1000 at the next edge.
REQ-036 RST pulsed mid-burst (owner 3, bus=16'h1234) -> gnt=0, bus=0, bus_valid=0 asynchronously; first post-reset grant to the lowest-index requester.
